// File: rtl/mips_mem_arbiter.sv
// Two-port memory arbiter for a MIPS core: instruction fetch and data share one
// fixed-latency memory; data has priority, but fetch is forced in after MAX_DEFER data wins.
module mips_mem_arbiter #(
    parameter int AW        = 10,
    parameter int DW        = 32,
    parameter int LAT       = 2,
    parameter int MAX_DEFER = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int LW  = $clog2(LAT + 1);
    localparam int DFW = $clog2(MAX_DEFER + 1);
    localparam logic [LW-1:0]  LAT_END   = LW'(LAT);
    localparam logic [DFW-1:0] DEFER_MAX = DFW'(MAX_DEFER);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t         state;
    logic [LW-1:0]  lat_cnt;
    logic [DFW-1:0] defer_cnt;
    logic           owner_d;
    logic           owner_we;
    logic           can_grant;
    logic           pick_d;
    logic           pick_i;

    // Grant is decided combinationally so the memory strobe lands in the request cycle;
    // gating with rst_n keeps every output quiet while reset is held.
    always_comb begin
        can_grant = rst_n && (state == IDLE);
        pick_d    = can_grant && d_req && !(if_req && (defer_cnt == DEFER_MAX));
        pick_i    = can_grant && if_req && !pick_d;
    end

    assign if_gnt    = pick_i;
    assign d_gnt     = pick_d;
    assign mem_en    = pick_i | pick_d;
    assign mem_we    = pick_d & d_we;
    assign mem_addr  = pick_d ? d_addr : (pick_i ? if_addr : '0);
    assign mem_wdata = pick_d ? d_wdata : '0;
    assign busy      = (state == WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            defer_cnt <= '0;
            owner_d   <= 1'b0;
            owner_we  <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_i || pick_d) begin
                        state    <= WAIT;
                        lat_cnt  <= LW'(1);
                        owner_d  <= pick_d;
                        owner_we <= pick_d & d_we;
                    end
                    // Only data wins that actually starve a waiting fetch count toward forcing it
                    if (pick_i)
                        defer_cnt <= '0;
                    else if (pick_d && if_req && (defer_cnt != DEFER_MAX))
                        defer_cnt <= defer_cnt + 1'b1;
                end
                WAIT: begin
                    if (lat_cnt == LAT_END) begin
                        state   <= IDLE;
                        lat_cnt <= '0;
                        if (owner_d) begin
                            d_rvalid <= 1'b1;
                            if (!owner_we)
                                d_rdata <= mem_rdata;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
